iir_freq_sweep_ctrl: RTL
========================

Name: iir_freq_sweep_ctrl

Overview:
- Sequencer for the IIR notch-filter frequency-response evaluator.
- On a start pulse it walks the phase (frequency-vector) memory from index 0 to config_nfft-1 and feeds one phase word per cycle into the fixed-latency evaluator pipeline.
- It collects every tf_val result in order and writes it into the spectrum result buffer at the matching index, then signals done/error to the host control FSM.
- It replaces testbench-style fixed-delay sampling with counted, self-checking result capture.

Parameters:
CONFIG_SIZE, 16, width of config_nfft
PHASE_BITS, 16, width of phase words and result phase
MAG_BITS, 16, width of result magnitude
ADDR_BITS, 11, phase/result memory address width (max 2048 points)
LATENCY, 5, evaluator cycles from eval_valid to res_valid

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle sweep request; ignored while busy
abort  in  1  cancel sweep
config_nfft  in  CONFIG_SIZE  number of points, sampled on accepted start
phase_rd_en  out  1  phase memory read strobe
phase_addr  out  ADDR_BITS  phase memory read address
phase_rd_data  in  PHASE_BITS  phase memory data, valid one cycle after phase_rd_en
eval_valid  out  1  phase word presented to evaluator
eval_phase  out  PHASE_BITS  phase word to evaluator
res_valid  in  1  evaluator result strobe
res_magnitude  in  MAG_BITS  evaluator magnitude
res_phase  in  PHASE_BITS  evaluator phase
wr_en  out  1  result buffer write strobe
wr_addr  out  ADDR_BITS  result index
wr_magnitude  out  MAG_BITS  registered magnitude
wr_phase  out  PHASE_BITS  registered phase
busy  out  1  sweep in progress
done  out  1  one-cycle completion pulse
error  out  1  sticky error flag; cleared on next accepted start

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; counters 0.
- States: IDLE, ISSUE, DRAIN, FINISH.
- Timing: cycle 0 is the cycle after the edge that sampled start.
- IDLE: start=1 latches N=config_nfft and clears error.
  - N=0: go to FINISH; done in cycle 0; no reads.
  - N>2^ADDR_BITS: set error, go to FINISH; done in cycle 0; no reads.
  - Otherwise go to ISSUE.
- ISSUE: phase_rd_en=1 and phase_addr=k in cycles k=0..N-1. Go to DRAIN after the read for N-1 is issued.
- Evaluator feed: eval_valid is phase_rd_en delayed one cycle. eval_phase=phase_rd_data in the same cycle (combinational pass-through).
- Result capture: an independent receive counter r starts at 0.
  - Each res_valid in ISSUE/DRAIN registers res_magnitude/res_phase to wr_magnitude/wr_phase, with wr_addr=r and wr_en=1 in the next cycle; then r increments.
- DRAIN: when the N-th result has been written, go to FINISH.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Nominal timing: results arrive in cycles 1+LATENCY..N+LATENCY; wr_en in cycles 2+LATENCY..N+1+LATENCY; done in cycle N+2+LATENCY.
- busy=1 in ISSUE and DRAIN and until the cycle done is asserted; done and busy are never both 1.
- Watchdog: in DRAIN, LATENCY+2 consecutive cycles without res_valid while results are outstanding → set error, go to FINISH (done pulses).
- Extra res_valid: after r=N, or while IDLE, the pulse is dropped; in ISSUE/DRAIN it also sets error.
- abort (priority over everything except reset): next state IDLE, no done, phase_rd_en/eval_valid/wr_en deasserted the next cycle. In-flight results then arrive in IDLE and are discarded without error.
- start while busy: ignored. start and abort in the same cycle in IDLE: abort wins, no sweep.
- Reset mid-sweep: immediate return to reset values. The result buffer is not written afterwards.

Optional Feature:
- Macro IIR_SWEEP_NOTCH_TRACK_EN.
- Defined: adds outputs notch_magnitude (MAG_BITS) and notch_index (ADDR_BITS).
  - Both are cleared to all-ones/0 on an accepted start and updated on each write whose magnitude is strictly less than the current minimum, so the first minimum wins ties.
  - Both are stable and valid when done pulses.
- Not defined: ports absent; no comparator logic.

Test Plan:
- N=4, LATENCY=5, evaluator model echoes phase as magnitude → phase_rd_en cycles 0..3 with addr 0..3; wr_en cycles 7..10 with wr_addr 0..3 in order; done in cycle 11; error=0.
- N=0 → done in cycle 0, no phase_rd_en, no wr_en, error=0. N=2049 with ADDR_BITS=11 → done in cycle 0, error=1.
- N=8, abort in cycle 3 → no reads from cycle 4; remaining res_valid pulses produce no wr_en; done never pulses; error=0; a new start then completes normally.
- N=4, evaluator withholds the last result → error=1, done 7 cycles after the last received res_valid, exactly 3 writes.
- start pulsed in cycle 2 of a running N=4 sweep → ignored; exactly 4 writes; single done pulse.
- With IIR_SWEEP_NOTCH_TRACK_EN, N=6, magnitudes 0x2000,0x1800,0x0400,0x0400,0x1000,0x2000 → notch_magnitude=0x0400, notch_index=2 at done.

Source files
------------

// File: rtl/iir_freq_sweep_ctrl.sv
// Frequency-sweep sequencer: reads N phase words, feeds the evaluator pipeline and writes
// every result back by index. Optional notch tracking behind IIR_SWEEP_NOTCH_TRACK_EN.
module iir_freq_sweep_ctrl #(
  parameter int CONFIG_SIZE = 16,
  parameter int PHASE_BITS  = 16,
  parameter int MAG_BITS    = 16,
  parameter int ADDR_BITS   = 11,
  parameter int LATENCY     = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CONFIG_SIZE-1:0] config_nfft,
  output logic                   phase_rd_en,
  output logic [ADDR_BITS-1:0]   phase_addr,
  input  logic [PHASE_BITS-1:0]  phase_rd_data,
  output logic                   eval_valid,
  output logic [PHASE_BITS-1:0]  eval_phase,
  input  logic                   res_valid,
  input  logic [MAG_BITS-1:0]    res_magnitude,
  input  logic [PHASE_BITS-1:0]  res_phase,
  output logic                   wr_en,
  output logic [ADDR_BITS-1:0]   wr_addr,
  output logic [MAG_BITS-1:0]    wr_magnitude,
  output logic [PHASE_BITS-1:0]  wr_phase,
  output logic                   busy,
  output logic                   done,
  output logic                   error
`ifdef IIR_SWEEP_NOTCH_TRACK_EN
  ,
  output logic [MAG_BITS-1:0]    notch_magnitude,
  output logic [ADDR_BITS-1:0]   notch_index
`endif
);

  // Counts hold 0..2^ADDR_BITS, one bit wider than an address.
  localparam int CNT_W = ADDR_BITS + 1;
  localparam int WD_W  = $clog2(LATENCY + 3);
  localparam logic [CONFIG_SIZE-1:0] MAX_N = CONFIG_SIZE'(2 ** ADDR_BITS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FINISH} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       n_q, n_d;
  logic [CNT_W-1:0]       rcv_q, rcv_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic                   phase_rd_en_q, phase_rd_en_d;
  logic [ADDR_BITS-1:0]   phase_addr_q, phase_addr_d;
  logic                   eval_valid_q, eval_valid_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [MAG_BITS-1:0]    wr_mag_q, wr_mag_d;
  logic [PHASE_BITS-1:0]  wr_phase_q, wr_phase_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
`ifdef IIR_SWEEP_NOTCH_TRACK_EN
  logic [MAG_BITS-1:0]    notch_mag_q, notch_mag_d;
  logic [ADDR_BITS-1:0]   notch_idx_q, notch_idx_d;
`endif

  logic in_sweep, take_res, extra_res;
  assign in_sweep  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign take_res  = res_valid && in_sweep && (rcv_q != n_q);
  assign extra_res = res_valid && in_sweep && (rcv_q == n_q);

  always_comb begin
    // NOTE: every _d starts from a default so no path through this block infers a latch.
    state_d       = state_q;
    n_d           = n_q;
    rcv_d         = rcv_q;
    wd_d          = '0;
    phase_rd_en_d = 1'b0;
    phase_addr_d  = phase_addr_q;
    eval_valid_d  = phase_rd_en_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_mag_d      = wr_mag_q;
    wr_phase_d    = wr_phase_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    error_d       = error_q;
`ifdef IIR_SWEEP_NOTCH_TRACK_EN
    notch_mag_d   = notch_mag_q;
    notch_idx_d   = notch_idx_q;
`endif

    if (abort) begin
      state_d      = S_IDLE;
      eval_valid_d = 1'b0;
      busy_d       = 1'b0;
    end else begin
      if (take_res) begin
        wr_en_d    = 1'b1;
        wr_addr_d  = rcv_q[ADDR_BITS-1:0];
        wr_mag_d   = res_magnitude;
        wr_phase_d = res_phase;
        rcv_d      = rcv_q + CNT_W'(1);
`ifdef IIR_SWEEP_NOTCH_TRACK_EN
        if (res_magnitude < notch_mag_q) begin
          notch_mag_d = res_magnitude;
          notch_idx_d = rcv_q[ADDR_BITS-1:0];
        end
`endif
      end
      if (extra_res) error_d = 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_d     = CNT_W'(config_nfft);
            rcv_d   = '0;
            error_d = 1'b0;
`ifdef IIR_SWEEP_NOTCH_TRACK_EN
            notch_mag_d = '1;
            notch_idx_d = '0;
`endif
            if (config_nfft == '0 || config_nfft > MAX_N) begin
              error_d = (config_nfft != '0);
              state_d = S_FINISH;
              done_d  = 1'b1;
            end else begin
              state_d       = S_ISSUE;
              busy_d        = 1'b1;
              phase_rd_en_d = 1'b1;
              phase_addr_d  = '0;
            end
          end
        end
        S_ISSUE: begin
          if ({1'b0, phase_addr_q} == n_q - CNT_W'(1)) begin
            state_d = S_DRAIN;
          end else begin
            phase_rd_en_d = 1'b1;
            phase_addr_d  = phase_addr_q + ADDR_BITS'(1);
          end
        end
        S_DRAIN: begin
          // The watchdog's Nth quiet cycle is the done cycle itself.
          wd_d = res_valid ? '0 : wd_q + WD_W'(1);
          if (rcv_q == n_q) begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (!res_valid && wd_q == WD_W'(LATENCY)) begin
            state_d = S_FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            error_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      n_q           <= '0;
      rcv_q         <= '0;
      wd_q          <= '0;
      phase_rd_en_q <= 1'b0;
      phase_addr_q  <= '0;
      eval_valid_q  <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_mag_q      <= '0;
      wr_phase_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
`ifdef IIR_SWEEP_NOTCH_TRACK_EN
      notch_mag_q   <= '0;
      notch_idx_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      n_q           <= n_d;
      rcv_q         <= rcv_d;
      wd_q          <= wd_d;
      phase_rd_en_q <= phase_rd_en_d;
      phase_addr_q  <= phase_addr_d;
      eval_valid_q  <= eval_valid_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_mag_q      <= wr_mag_d;
      wr_phase_q    <= wr_phase_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
`ifdef IIR_SWEEP_NOTCH_TRACK_EN
      notch_mag_q   <= notch_mag_d;
      notch_idx_q   <= notch_idx_d;
`endif
    end
  end

  assign phase_rd_en  = phase_rd_en_q;
  assign phase_addr   = phase_addr_q;
  assign eval_valid   = eval_valid_q;
  assign eval_phase   = phase_rd_data;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_magnitude = wr_mag_q;
  assign wr_phase     = wr_phase_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
`ifdef IIR_SWEEP_NOTCH_TRACK_EN
  assign notch_magnitude = notch_mag_q;
  assign notch_index     = notch_idx_q;
`endif

endmodule
